// File: rtl/seq_mag_compare_if.sv
// Handshake and result bundle for the bit-serial magnitude comparator.
// The master drives the operands and start; the slave returns the status and the result.
interface seq_mag_compare_if #(
    parameter int W = 8
);
    localparam int BW = $clog2(W + 1);

    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [5:0]    flags;
    logic [6:0]    hex;
    logic [BW-1:0] bits_used;

    modport master (
        output start, a, b,
        input  busy, done, flags, hex, bits_used
    );

    modport slave (
        input  start, a, b,
        output busy, done, flags, hex, bits_used
    );
endinterface

// File: rtl/seq_mag_compare.sv
// Bit-serial, MSB-first magnitude comparator.
// Produces registered relational flags and an active-low 7-segment glyph of the outcome.
module seq_mag_compare #(
    parameter int W          = 8,
    parameter int SIGNED     = 0,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    seq_mag_compare_if.slave bus
);
    localparam int IW = $clog2(W);
    localparam int BW = $clog2(W + 1);
    localparam logic [IW-1:0] MSB_IDX = IW'(W - 1);

    localparam logic [6:0] HEX_GT    = 7'b0010000;
    localparam logic [6:0] HEX_LT    = 7'b1000111;
    localparam logic [6:0] HEX_EQ    = 7'b0000110;
    localparam logic [6:0] HEX_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state;
    state_t        state_nx;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [IW-1:0] idx;
    logic          decided;
    logic          dec_gt;
    logic [5:0]    flags_q;
    logic [6:0]    hex_q;
    logic [BW-1:0] bits_q;

    logic          bit_a;
    logic          bit_b;
    logic          bit_diff;
    logic          bit_gt;
    logic          last;
    logic          fin_gt;
    logic          fin_lt;
    logic          fin_eq;
    logic [6:0]    hex_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // With early exit disabled, the first differing bit has already decided the outcome
    // and later differing bits must not override it.
    always_comb begin
        state_nx = state;
        bit_a    = a_q[idx];
        bit_b    = b_q[idx];
        bit_diff = bit_a ^ bit_b;
        bit_gt   = ((SIGNED != 0) && (idx == MSB_IDX)) ? ~bit_a : bit_a;
        last     = (bit_diff && (EARLY_EXIT != 0)) || (idx == '0);
        fin_gt   = decided ? dec_gt  : (bit_diff & bit_gt);
        fin_lt   = decided ? ~dec_gt : (bit_diff & ~bit_gt);
        fin_eq   = ~fin_gt & ~fin_lt;
        hex_nx   = fin_gt ? HEX_GT : (fin_lt ? HEX_LT : HEX_EQ);
        case (state)
            IDLE:    if (bus.start) state_nx = SHIFT;
            SHIFT:   if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            idx     <= '0;
            decided <= 1'b0;
            dec_gt  <= 1'b0;
            flags_q <= '0;
            hex_q   <= HEX_BLANK;
            bits_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        idx     <= MSB_IDX;
                        decided <= 1'b0;
                        dec_gt  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (!decided && bit_diff) begin
                        decided <= 1'b1;
                        dec_gt  <= bit_gt;
                    end
                    if (last) begin
                        flags_q <= {fin_gt, fin_gt | fin_eq, fin_lt, fin_lt | fin_eq, fin_eq, ~fin_eq};
                        hex_q   <= hex_nx;
                        bits_q  <= BW'(W) - BW'(idx);
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.flags     = flags_q;
    assign bus.hex       = hex_q;
    assign bus.bits_used = bits_q;
endmodule

// File: tb/tb_seq_mag_compare.sv
// Runs the same operations through all four SIGNED/EARLY_EXIT configurations of the comparator
// and checks each one against table entries and an arithmetic reference model.
module tb_seq_mag_compare;
    localparam int W    = 8;
    localparam int NCFG = 4;
    localparam int BW   = $clog2(W + 1);

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;

    logic [NCFG-1:0] busy_v;
    logic [NCFG-1:0] done_v;
    logic [5:0]      flags_v [NCFG];
    logic [6:0]      hex_v   [NCFG];
    logic [BW-1:0]   bits_v  [NCFG];

    int total = 0;
    int bad   = 0;

    int         ndone     [NCFG];
    int         lat       [NCFG];
    logic [5:0] got_flags [NCFG];
    logic [6:0] got_hex   [NCFG];
    int         got_bits  [NCFG];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         cfg;
        logic [5:0] flags;
        logic [6:0] hex;
        int         bits;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    // Configuration g: bit 0 selects signed operands, g >= 2 disables early exit.
    for (genvar g = 0; g < NCFG; g++) begin : cfg
        seq_mag_compare_if #(.W(W)) bus ();
        assign bus.start  = start;
        assign bus.a      = a;
        assign bus.b      = b;
        assign busy_v[g]  = bus.busy;
        assign done_v[g]  = bus.done;
        assign flags_v[g] = bus.flags;
        assign hex_v[g]   = bus.hex;
        assign bits_v[g]  = bus.bits_used;

        seq_mag_compare #(
            .W(W),
            .SIGNED(g % 2),
            .EARLY_EXIT((g < 2) ? 1 : 0)
        ) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );
    end

    task automatic check_output(input string name, input int c, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s cfg=%0d actual=%0h required=%0h", name, c, act, exp);
        end
    endtask

    function automatic void model(input logic [7:0] av, input logic [7:0] bv, input int c,
                                  output logic [5:0] f, output logic [6:0] h, output int l);
        int sa;
        int sb;
        int p;
        logic [7:0] x;
        logic gt;
        logic lt;
        logic eq;
        sa = (c % 2 == 1) ? int'($signed(av)) : int'(av);
        sb = (c % 2 == 1) ? int'($signed(bv)) : int'(bv);
        gt = (sa > sb);
        lt = (sa < sb);
        eq = (sa == sb);
        f  = {gt, gt | eq, lt, lt | eq, eq, ~eq};
        h  = gt ? 7'b0010000 : (lt ? 7'b1000111 : 7'b0000110);
        x  = av ^ bv;
        p  = -1;
        for (int i = 0; i < W; i++) if (x[i]) p = i;
        l  = ((c < 2) && (p >= 0)) ? (W - p) : W;
    endfunction

    // Issues one start to every configuration, scrambles the operands after capture,
    // optionally pulses start again at cycle pulse_at, and records each done pulse.
    task automatic apply_stimulus(input logic [7:0] av, input logic [7:0] bv, input int pulse_at);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        for (int i = 0; i < NCFG; i++) begin
            ndone[i] = 0;
            lat[i]   = -1;
        end
        for (int cyc = 1; cyc <= W + 4; cyc++) begin
            start = (cyc == pulse_at);
            @(negedge clk);
            for (int i = 0; i < NCFG; i++) begin
                if (done_v[i]) begin
                    ndone[i]++;
                    if (lat[i] < 0) begin
                        lat[i]       = cyc;
                        got_flags[i] = flags_v[i];
                        got_hex[i]   = hex_v[i];
                        got_bits[i]  = int'(bits_v[i]);
                    end
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic verify_model(input logic [7:0] av, input logic [7:0] bv);
        logic [5:0] ef;
        logic [6:0] eh;
        int el;
        for (int i = 0; i < NCFG; i++) begin
            model(av, bv, i, ef, eh, el);
            check_output("done_count", i, ndone[i], 1);
            check_output("latency", i, lat[i], el);
            check_output("flags", i, int'(got_flags[i]), int'(ef));
            check_output("hex", i, int'(got_hex[i]), int'(eh));
            check_output("bits_used", i, got_bits[i], el);
            check_output("flags_held", i, int'(flags_v[i]), int'(ef));
            check_output("busy_idle", i, int'(busy_v[i]), 0);
        end
    endtask

    initial begin
        int nd;
        logic [7:0] ra;
        logic [7:0] rb;

        vecs[0] = '{8'h80, 8'h7F, 0, 6'b110001, 7'b0010000, 1};
        vecs[1] = '{8'h3C, 8'h3C, 0, 6'b010110, 7'b0000110, 8};
        vecs[2] = '{8'h80, 8'h01, 1, 6'b001101, 7'b1000111, 1};
        vecs[3] = '{8'h05, 8'h04, 2, 6'b110001, 7'b0010000, 8};
        vecs[4] = '{8'hFF, 8'h01, 3, 6'b001101, 7'b1000111, 8};
        vecs[5] = '{8'h01, 8'h02, 0, 6'b001101, 7'b1000111, 7};

        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NCFG; i++) begin
            check_output("reset_busy", i, int'(busy_v[i]), 0);
            check_output("reset_done", i, int'(done_v[i]), 0);
            check_output("reset_flags", i, int'(flags_v[i]), 0);
            check_output("reset_hex", i, int'(hex_v[i]), 7'h7F);
            check_output("reset_bits", i, int'(bits_v[i]), 0);
        end
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 6; k++) begin
            apply_stimulus(vecs[k].a, vecs[k].b, 0);
            check_output("vec_done_count", vecs[k].cfg, ndone[vecs[k].cfg], 1);
            check_output("vec_latency", vecs[k].cfg, lat[vecs[k].cfg], vecs[k].bits);
            check_output("vec_flags", vecs[k].cfg, int'(got_flags[vecs[k].cfg]), int'(vecs[k].flags));
            check_output("vec_hex", vecs[k].cfg, int'(got_hex[vecs[k].cfg]), int'(vecs[k].hex));
            check_output("vec_bits", vecs[k].cfg, got_bits[vecs[k].cfg], vecs[k].bits);
        end

        // A start pulse during SHIFT must neither queue nor produce a second done.
        apply_stimulus(8'h05, 8'h04, 3);
        verify_model(8'h05, 8'h04);

        // Reset asserted in the fourth SHIFT cycle aborts every configuration silently.
        nd    = 0;
        a     = 8'h01;
        b     = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            nd += $countones(done_v);
        end
        rst = 1'b1;
        @(negedge clk);
        nd += $countones(done_v);
        rst = 1'b0;
        for (int cyc = 0; cyc < W + 2; cyc++) begin
            @(negedge clk);
            nd += $countones(done_v);
        end
        check_output("abort_no_done", 0, nd, 0);
        for (int i = 0; i < NCFG; i++) begin
            check_output("abort_flags", i, int'(flags_v[i]), 0);
            check_output("abort_hex", i, int'(hex_v[i]), 7'h7F);
            check_output("abort_bits", i, int'(bits_v[i]), 0);
            check_output("abort_busy", i, int'(busy_v[i]), 0);
        end
        apply_stimulus(8'h01, 8'h00, 0);
        verify_model(8'h01, 8'h00);

        for (int n = 0; n < 40; n++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
            apply_stimulus(ra, rb, 0);
            verify_model(ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_mag_compare.md
Name: seq_mag_compare

Overview:
Parametrised, bit-serial, MSB-first magnitude comparator for two W-bit operands. It supports signed or unsigned operands and optional early termination. It produces the six relational flags as a registered vector in {gt, ge, lt, le, eq, ne} order, plus an active-low 7-segment result glyph. The block sits between the board switch/key inputs and the LEDR/HEX outputs, and it succeeds the 3-bit combinational comparator lab.

Parameters:
W, 8, operand width in bits (W >= 2)
SIGNED, 0, 1 = operands are two's complement; 0 = unsigned
EARLY_EXIT, 1, 1 = finish at the first differing bit; 0 = always scan all W bits

Ports:
clk  input  1  system clock, all state changes on the rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request a comparison; sampled only in IDLE
a  input  W  operand A; captured on the accepting edge
b  input  W  operand B; captured on the accepting edge
busy  output  1  high in SHIFT and DONE
done  output  1  one-cycle pulse when the result is valid
flags  output  6  registered {gt, ge, lt, le, eq, ne}; held until the next completion
hex  output  7  active-low 7-seg glyph: gt 7'b0010000 ("g"), lt 7'b1000111 ("L"), eq 7'b0000110 ("E"), blank 7'b1111111
bits_used  output  $clog2(W+1)  number of bit positions examined in the last comparison

Behaviour:
- One clock domain. Reset is synchronous and active-high. Clock port is clk; reset port is rst.
- Reset values:
  - state = IDLE
  - busy = 0, done = 0
  - flags = 6'b000000, hex = 7'b1111111, bits_used = 0
  - internal operand registers = 0
- rst overrides all other inputs on any edge, including mid-SHIFT or during DONE. An aborted comparison produces no done pulse and clears flags/hex.
- States:
  - IDLE:
    - start=1 → capture a, b; set bit index idx = W-1; go to SHIFT.
    - start=0 → stay in IDLE.
  - SHIFT: examine bit idx of the captured A (Ai) and B (Bi). A bit differs when Ai != Bi.
    - Polarity for a differing bit:
      - At idx = W-1 with SIGNED=1, A>B iff Ai=0.
      - Otherwise A>B iff Ai=1.
    - Go to DONE when either:
      - the bit differs and EARLY_EXIT=1, or
      - idx = 0.
    - Otherwise idx decrements and the state stays in SHIFT.
    - With EARLY_EXIT=0, the first differing bit decides the result. Later bits are scanned but ignored.
  - DONE:
    - done = 1 for exactly this cycle.
    - flags, hex and bits_used were loaded on the edge entering DONE and are stable in this cycle.
    - Unconditionally go to IDLE on the next edge.
- Flag rules:
  - gt = A>B, lt = A<B, eq = ~gt & ~lt.
  - ge = gt | eq, le = lt | eq, ne = ~eq.
  - Exactly one of gt/lt/eq is 1 after any completion.
- Latency is measured from the edge that samples start to the edge that enters DONE:
  - EARLY_EXIT=1: W-p edges, where p is the highest differing bit position; W edges if the operands are equal.
  - EARLY_EXIT=0: always W edges.
- bits_used = the latency value above.
- start while busy=1 (SHIFT or DONE) is ignored and is not queued.
- Changes on a/b after capture have no effect.
- Back-to-back operation: the minimum issue interval is latency + 2 cycles. start is accepted on the edge leaving DONE → IDLE only if it is still high in the following IDLE cycle.
- flags and hex retain the last result through IDLE and through subsequent SHIFT cycles. They update only on entry to DONE.

Test Plan:
- W=8, SIGNED=0, EARLY_EXIT=1, rst held 2 cycles → busy=0, done=0, flags=000000, hex=1111111, bits_used=0.
- Same config, a=8'h80, b=8'h7F, start for 1 cycle → done 1 edge later; flags=110001 (gt, ge, ne); hex=0010000; bits_used=1.
- Same config, a=8'h3C, b=8'h3C → done after 8 edges; flags=010110 (ge, le, eq); hex=0000110; bits_used=8.
- SIGNED=1, a=8'h80 (-128), b=8'h01 → flags=001101 (lt, le, ne); hex=1000111; bits_used=1.
- EARLY_EXIT=0, a=8'h05, b=8'h04 → done after exactly 8 edges; flags=110001; bits_used=8. Pulsing start again mid-SHIFT produces no extra done.
- Reset mid-op: start with a=8'h01, b=8'h00; assert rst on the 4th SHIFT cycle → no done; flags=000000, hex blank. A new start after release completes normally.
